// File: rtl/dma_channel_engine_if.sv
// ---------------------------------------------------------------------------
// dma_channel_engine_if
//
// Purpose: groups the CPU programming port and the transfer-step port of the
// DMA channel register/count engine into one bundle.
//
// Signals:
//   progWrite    CPU register write strobe, one cycle per byte
//   progRead     CPU register read strobe, one cycle per byte
//   progAddr     {func[1:0], ch[CH_W-1:0]}
//   progDataIn   CPU write data
//   progDataOut  registered read data (engine -> CPU)
//   xferStep     one transfer completed on channel xferCh
//   xferCh       channel selected for xferStep and addrOut
//   addrOut      registered current address of xferCh
//   tcPulse      one-cycle pulse when a step reaches terminal count
//   chMask       per-channel inhibit mask (1 = inhibited)
//
// Modports: slave = the engine, master = bus decode / timing FSM side.
// ---------------------------------------------------------------------------
interface dma_channel_engine_if #(
  parameter int CHANNELS     = 4,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 16
);
  localparam int CH_W = $clog2(CHANNELS);

  logic                    progWrite;
  logic                    progRead;
  logic [CH_W+1:0]         progAddr;
  logic [DATAWIDTH-1:0]    progDataIn;
  logic [DATAWIDTH-1:0]    progDataOut;
  logic                    xferStep;
  logic [CH_W-1:0]         xferCh;
  logic [ADDRESSWIDTH-1:0] addrOut;
  logic                    tcPulse;
  logic [CHANNELS-1:0]     chMask;

  modport slave (
    input  progWrite, progRead, progAddr, progDataIn, xferStep, xferCh,
    output progDataOut, addrOut, tcPulse, chMask
  );

  modport master (
    output progWrite, progRead, progAddr, progDataIn, xferStep, xferCh,
    input  progDataOut, addrOut, tcPulse, chMask
  );
endinterface

// File: rtl/dma_channel_engine.sv
// ---------------------------------------------------------------------------
// dma_channel_engine
//
// Purpose: per-channel DMA register/count engine. Holds base/current address
// and base/current word count for CHANNELS channels, programmed byte-serially
// through a shared byte pointer. Each unmasked transfer step moves the current
// address by +/-1 and decrements the count; a step taken with a count of zero
// is terminal count (TC), which pulses tcPulse, latches a status bit and
// either reloads from base (autoinit) or masks the channel.
//
// Ports:
//   CLK    system clock
//   RESET  synchronous, active-high reset
//   bus    dma_channel_engine_if.slave (programming + transfer-step signals)
//
// Register map (progAddr = {func, ch}):
//   func 0  base+current address of ch (byte-serial)
//   func 1  base+current word count of ch (byte-serial, write unmasks ch)
//   func 2  mode: [0] autoinit, [1] decrement, [2] address hold (optional)
//   func 3  ch0 wr: clear byte pointer, ch1 rd: status (read-to-clear),
//           ch2 wr: master clear, ch3 wr: unmask channel progDataIn[CH_W-1:0]
//
// Optional feature: define DMA_ADDR_HOLD_EN to build the per-channel
// address-hold mode bit (steps decrement the count but keep the address).
// ---------------------------------------------------------------------------
module dma_channel_engine #(
  parameter int CHANNELS     = 4,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 16
) (
  input logic                 CLK,
  input logic                 RESET,
  dma_channel_engine_if.slave bus
);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int BYTES = ADDRESSWIDTH / DATAWIDTH;
  localparam int PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef logic [ADDRESSWIDTH-1:0] word_t;

  word_t               base_addr_q [CHANNELS];
  word_t               base_addr_d [CHANNELS];
  word_t               cur_addr_q  [CHANNELS];
  word_t               cur_addr_d  [CHANNELS];
  word_t               base_cnt_q  [CHANNELS];
  word_t               base_cnt_d  [CHANNELS];
  word_t               cur_cnt_q   [CHANNELS];
  word_t               cur_cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] autoinit_q, autoinit_d;
  logic [CHANNELS-1:0] decr_q, decr_d;
`ifdef DMA_ADDR_HOLD_EN
  logic [CHANNELS-1:0] hold_q, hold_d;
`endif
  logic [CHANNELS-1:0] tc_q, tc_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  word_t               addr_out_q;
  logic                tc_pulse_q;

  logic [1:0]          func;
  logic [CH_W-1:0]     ch;
  logic [31:0]         ch_ext;
  logic [31:0]         byte_lsb;
  logic                wr;
  logic                rd;
  logic                mclr;
  logic                ch_write_hit;
  logic                step_ok;
  logic                tc_hit;

  function automatic word_t step_addr(input word_t a, input logic dec);
    return dec ? (a - word_t'(1)) : (a + word_t'(1));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == BYTES - 1) ? '0 : (p + PTR_W'(1));
  endfunction

  assign func     = bus.progAddr[CH_W+1:CH_W];
  assign ch       = bus.progAddr[CH_W-1:0];
  assign ch_ext   = 32'(ch);
  assign byte_lsb = 32'(ptr_q) * DATAWIDTH;

  // A simultaneous write and read is a write; the read side is discarded.
  assign wr   = bus.progWrite;
  assign rd   = bus.progRead & ~bus.progWrite;
  assign mclr = wr && (func == 2'd3) && (ch_ext == 32'd2);

  // A register/mode write to the stepping channel wins; the step is dropped.
  assign ch_write_hit = wr && (func != 2'd3) && (ch == bus.xferCh);
  assign step_ok      = bus.xferStep && !mask_q[bus.xferCh] && !ch_write_hit;
  assign tc_hit       = step_ok && (cur_cnt_q[bus.xferCh] == '0);

  always_comb begin
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    autoinit_d  = autoinit_q;
    decr_d      = decr_q;
`ifdef DMA_ADDR_HOLD_EN
    hold_d      = hold_q;
`endif
    tc_d        = tc_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    dout_d      = dout_q;

    // Status clear happens before the step so a same-cycle TC stays latched.
    if (rd) begin
      dout_d = '0;
      if (func == 2'd0) begin
        dout_d = cur_addr_q[ch][byte_lsb +: DATAWIDTH];
        ptr_d  = ptr_inc(ptr_q);
      end else if (func == 2'd1) begin
        dout_d = cur_cnt_q[ch][byte_lsb +: DATAWIDTH];
        ptr_d  = ptr_inc(ptr_q);
      end else if ((func == 2'd3) && (ch_ext == 32'd1)) begin
        dout_d = DATAWIDTH'(tc_q);
        tc_d   = '0;
      end
    end

    if (step_ok) begin
      cur_cnt_d[bus.xferCh] = cur_cnt_q[bus.xferCh] - word_t'(1);
`ifdef DMA_ADDR_HOLD_EN
      if (!hold_q[bus.xferCh])
`endif
        cur_addr_d[bus.xferCh] = step_addr(cur_addr_q[bus.xferCh], decr_q[bus.xferCh]);
      if (tc_hit) begin
        tc_d[bus.xferCh] = 1'b1;
        if (autoinit_q[bus.xferCh]) begin
          cur_addr_d[bus.xferCh] = base_addr_q[bus.xferCh];
          cur_cnt_d[bus.xferCh]  = base_cnt_q[bus.xferCh];
        end else begin
          mask_d[bus.xferCh] = 1'b1;
        end
      end
    end

    if (wr) begin
      case (func)
        2'd0: begin
          base_addr_d[ch][byte_lsb +: DATAWIDTH] = bus.progDataIn;
          cur_addr_d[ch][byte_lsb +: DATAWIDTH]  = bus.progDataIn;
          ptr_d = ptr_inc(ptr_q);
        end
        2'd1: begin
          base_cnt_d[ch][byte_lsb +: DATAWIDTH] = bus.progDataIn;
          cur_cnt_d[ch][byte_lsb +: DATAWIDTH]  = bus.progDataIn;
          mask_d[ch] = 1'b0;
          ptr_d = ptr_inc(ptr_q);
        end
        2'd2: begin
          autoinit_d[ch] = bus.progDataIn[0];
          decr_d[ch]     = bus.progDataIn[1];
`ifdef DMA_ADDR_HOLD_EN
          hold_d[ch]     = bus.progDataIn[2];
`endif
        end
        default: begin
          // Master clear (ch2) is applied in the register process.
          if (ch_ext == 32'd0) begin
            ptr_d = '0;
          end
          if (ch_ext == 32'd3) begin
            mask_d[bus.progDataIn[CH_W-1:0]] = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || mclr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
      end
      autoinit_q <= '0;
      decr_q     <= '0;
`ifdef DMA_ADDR_HOLD_EN
      hold_q     <= '0;
`endif
      tc_q       <= '0;
      mask_q     <= '1;
      ptr_q      <= '0;
      dout_q     <= '0;
      addr_out_q <= '0;
      tc_pulse_q <= 1'b0;
    end else begin
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
      autoinit_q  <= autoinit_d;
      decr_q      <= decr_d;
`ifdef DMA_ADDR_HOLD_EN
      hold_q      <= hold_d;
`endif
      tc_q        <= tc_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      dout_q      <= dout_d;
      addr_out_q  <= cur_addr_d[bus.xferCh];
      tc_pulse_q  <= tc_hit;
    end
  end

  assign bus.progDataOut = dout_q;
  assign bus.addrOut     = addr_out_q;
  assign bus.tcPulse     = tc_pulse_q;
  assign bus.chMask      = mask_q;

endmodule

// File: tb/tb_dma_channel_engine.sv
`timescale 1ns/1ps
module tb_dma_channel_engine;
  localparam int CHANNELS = 4;
  localparam int DW       = 8;
  localparam int AW       = 16;
  localparam int BYTES    = AW / DW;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dma_channel_engine_if #(.CHANNELS(CHANNELS), .DATAWIDTH(DW), .ADDRESSWIDTH(AW)) bus ();

  dma_channel_engine #(.CHANNELS(CHANNELS), .DATAWIDTH(DW), .ADDRESSWIDTH(AW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Reference model: plain integers per channel, updated by the register-map rules.
  int unsigned m_base_addr [CHANNELS];
  int unsigned m_cur_addr  [CHANNELS];
  int unsigned m_base_cnt  [CHANNELS];
  int unsigned m_cur_cnt   [CHANNELS];
  bit          m_auto      [CHANNELS];
  bit          m_dec       [CHANNELS];
  bit          m_hold      [CHANNELS];
  bit [3:0]    m_tc;
  bit [3:0]    m_mask;
  int          m_ptr;
  logic [7:0]  e_dout;
  logic [15:0] e_addr;
  logic        e_tcp;

  int n_checks;
  int n_fail;

  function automatic int unsigned put_byte(int unsigned v, int p, int b);
    int unsigned bb;
    bb = b & 32'hFF;
    return ((v & ~(32'hFF << (8 * p))) | (bb << (8 * p))) & 32'hFFFF;
  endfunction

  function automatic logic [7:0] get_byte(int unsigned v, int p);
    int unsigned t;
    t = (v >> (8 * p)) & 32'hFF;
    return t[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_base_addr[i] = 0; m_cur_addr[i] = 0; m_base_cnt[i] = 0; m_cur_cnt[i] = 0;
      m_auto[i] = 0; m_dec[i] = 0; m_hold[i] = 0;
    end
    m_tc = '0; m_mask = '1; m_ptr = 0;
    e_dout = '0; e_addr = '0; e_tcp = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.progWrite = 1'b0; bus.progRead = 1'b0; bus.progAddr = '0;
    bus.progDataIn = '0; bus.xferStep = 1'b0; bus.xferCh = '0;
  endtask

  // One clock: drive inputs, advance the model, wait past the edge.
  task automatic cyc(input int wr, input int rd, input int func, input int ch,
                     input int din, input int st, input int sch);
    bit w, r, same, stepping, tch;
    int p;
    bus.progWrite  = wr[0];
    bus.progRead   = rd[0];
    bus.progAddr   = {func[1:0], ch[1:0]};
    bus.progDataIn = din[7:0];
    bus.xferStep   = st[0];
    bus.xferCh     = sch[1:0];
    w = wr[0];
    r = rd[0] && !w;
    if (w && func == 3 && ch == 2) begin
      model_reset();
    end else begin
      same     = w && (func != 3) && (ch == sch);
      stepping = st[0] && !m_mask[sch] && !same;
      tch      = stepping && (m_cur_cnt[sch] == 0);
      p        = m_ptr;
      if (r) begin
        if (func == 0) begin
          e_dout = get_byte(m_cur_addr[ch], p); m_ptr = (m_ptr + 1) % BYTES;
        end else if (func == 1) begin
          e_dout = get_byte(m_cur_cnt[ch], p); m_ptr = (m_ptr + 1) % BYTES;
        end else if (func == 3 && ch == 1) begin
          e_dout = {4'b0, m_tc}; m_tc = '0;
        end else begin
          e_dout = '0;
        end
      end
      if (stepping) begin
        m_cur_cnt[sch] = (m_cur_cnt[sch] - 1) & 32'hFFFF;
        if (!m_hold[sch])
          m_cur_addr[sch] = (m_dec[sch] ? m_cur_addr[sch] - 1 : m_cur_addr[sch] + 1) & 32'hFFFF;
        if (tch) begin
          m_tc[sch] = 1'b1;
          if (m_auto[sch]) begin
            m_cur_addr[sch] = m_base_addr[sch];
            m_cur_cnt[sch]  = m_base_cnt[sch];
          end else begin
            m_mask[sch] = 1'b1;
          end
        end
      end
      if (w) begin
        case (func)
          0: begin
            m_base_addr[ch] = put_byte(m_base_addr[ch], m_ptr, din);
            m_cur_addr[ch]  = put_byte(m_cur_addr[ch], m_ptr, din);
            m_ptr = (m_ptr + 1) % BYTES;
          end
          1: begin
            m_base_cnt[ch] = put_byte(m_base_cnt[ch], m_ptr, din);
            m_cur_cnt[ch]  = put_byte(m_cur_cnt[ch], m_ptr, din);
            m_mask[ch] = 1'b0;
            m_ptr = (m_ptr + 1) % BYTES;
          end
          2: begin
            m_auto[ch] = din[0];
            m_dec[ch]  = din[1];
`ifdef DMA_ADDR_HOLD_EN
            m_hold[ch] = din[2];
`endif
          end
          default: begin
            if (ch == 0) m_ptr = 0;
            if (ch == 3) m_mask[din[1:0]] = 1'b0;
          end
        endcase
      end
      e_tcp  = tch;
      e_addr = m_cur_addr[sch][15:0];
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (bus.progDataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.progDataOut); end
    n_checks++;
    if (bus.addrOut !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", bus.addrOut); end
    n_checks++;
    if (bus.tcPulse !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b expected 0", bus.tcPulse); end
    n_checks++;
    if (bus.chMask !== 4'hF) begin n_fail++; $display("FAIL reset_mask: got %h expected f", bus.chMask); end
    rst = 1'b0;
  endtask

  task automatic test_program_readback();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h34, 8'h12, 8'h02, 8'h00};
    cyc(1, 0, 0, 1, 8'h34, 0, 1);
    cyc(1, 0, 0, 1, 8'h12, 0, 1);
    cyc(1, 0, 1, 1, 8'h02, 0, 1);
    cyc(1, 0, 1, 1, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, (i < 2) ? 0 : 1, 1, 0, 0, 1);
      n_checks++;
      if (bus.progDataOut !== exp_rd[i]) begin
        n_fail++; $display("FAIL readback[%0d]: got %h expected %h", i, bus.progDataOut, exp_rd[i]);
      end
    end
    n_checks++;
    if (bus.chMask[1] !== 1'b0) begin n_fail++; $display("FAIL prog_unmask: got %b expected 0", bus.chMask[1]); end
    n_checks++;
    if (bus.addrOut !== 16'h1234) begin n_fail++; $display("FAIL prog_addrout: got %h expected 1234", bus.addrOut); end
  endtask

  task automatic test_steps();
    logic [15:0] exp_a [4];
    logic        exp_t [4];
    exp_a = '{16'h1235, 16'h1236, 16'h1237, 16'h1237};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      n_checks++;
      if (bus.addrOut !== exp_a[i]) begin
        n_fail++; $display("FAIL step_addr[%0d]: got %h expected %h", i, bus.addrOut, exp_a[i]);
      end
      n_checks++;
      if (bus.tcPulse !== exp_t[i]) begin
        n_fail++; $display("FAIL step_tc[%0d]: got %b expected %b", i, bus.tcPulse, exp_t[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (bus.chMask[1] !== 1'b1) begin n_fail++; $display("FAIL tc_mask: got %b expected 1", bus.chMask[1]); end
      end
    end
  endtask

  task automatic test_autoinit_decrement();
    cyc(0, 1, 3, 1, 0, 0, 2);
    n_checks++;
    if (bus.progDataOut !== 8'h02) begin n_fail++; $display("FAIL status_ch1: got %h expected 02", bus.progDataOut); end
    cyc(1, 0, 2, 2, 8'h03, 0, 2);
    cyc(1, 0, 0, 2, 8'h00, 0, 2);
    cyc(1, 0, 0, 2, 8'h00, 0, 2);
    cyc(1, 0, 1, 2, 8'h00, 0, 2);
    cyc(1, 0, 1, 2, 8'h00, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 2);
    n_checks++;
    if (bus.tcPulse !== 1'b1) begin n_fail++; $display("FAIL auto_tc0: got %b expected 1", bus.tcPulse); end
    n_checks++;
    if (bus.addrOut !== 16'h0000) begin n_fail++; $display("FAIL auto_reload0: got %h expected 0000", bus.addrOut); end
    n_checks++;
    if (bus.chMask[2] !== 1'b0) begin n_fail++; $display("FAIL auto_mask: got %b expected 0", bus.chMask[2]); end
    cyc(1, 0, 1, 2, 8'h01, 0, 2);
    cyc(1, 0, 1, 2, 8'h00, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 2);
    n_checks++;
    if (bus.addrOut !== 16'hFFFF || bus.tcPulse !== 1'b0) begin
      n_fail++; $display("FAIL dec_wrap: got addr %h tc %b expected ffff 0", bus.addrOut, bus.tcPulse);
    end
    cyc(0, 0, 0, 0, 0, 1, 2);
    n_checks++;
    if (bus.addrOut !== 16'h0000 || bus.tcPulse !== 1'b1) begin
      n_fail++; $display("FAIL dec_reload: got addr %h tc %b expected 0000 1", bus.addrOut, bus.tcPulse);
    end
    cyc(0, 1, 3, 1, 0, 0, 2);
    n_checks++;
    if (bus.progDataOut !== 8'h04) begin n_fail++; $display("FAIL status_ch2: got %h expected 04", bus.progDataOut); end
    cyc(0, 1, 3, 1, 0, 0, 2);
    n_checks++;
    if (bus.progDataOut !== 8'h00) begin n_fail++; $display("FAIL status_clr: got %h expected 00", bus.progDataOut); end
  endtask

  task automatic test_ptr_clear();
    cyc(1, 0, 0, 0, 8'h11, 0, 0);
    cyc(1, 0, 0, 0, 8'h22, 0, 0);
    cyc(1, 0, 0, 0, 8'h55, 0, 0);
    cyc(1, 0, 3, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 8'hAB, 0, 0);
    n_checks++;
    if (bus.addrOut !== 16'h22AB) begin n_fail++; $display("FAIL ptr_addr: got %h expected 22ab", bus.addrOut); end
    cyc(1, 0, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.progDataOut !== 8'hAB) begin n_fail++; $display("FAIL ptr_lo: got %h expected ab", bus.progDataOut); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.progDataOut !== 8'h22) begin n_fail++; $display("FAIL ptr_hi: got %h expected 22", bus.progDataOut); end
  endtask

  task automatic test_write_step_collision();
    cyc(1, 0, 1, 0, 8'h00, 0, 0);
    cyc(1, 0, 1, 0, 8'h00, 0, 0);
    cyc(1, 0, 1, 0, 8'h07, 1, 0);
    n_checks++;
    if (bus.tcPulse !== 1'b0 || bus.addrOut !== 16'h22AB) begin
      n_fail++; $display("FAIL coll_step: got tc %b addr %h expected 0 22ab", bus.tcPulse, bus.addrOut);
    end
    cyc(1, 0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (bus.progDataOut !== 8'h07) begin n_fail++; $display("FAIL coll_cnt: got %h expected 07", bus.progDataOut); end
    cyc(0, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic test_status_collision();
    cyc(1, 0, 1, 3, 8'h00, 0, 3);
    cyc(1, 0, 1, 3, 8'h00, 0, 3);
    cyc(0, 1, 3, 1, 0, 1, 3);
    n_checks++;
    if (bus.progDataOut !== 8'h00 || bus.tcPulse !== 1'b1) begin
      n_fail++; $display("FAIL stat_coll: got dout %h tc %b expected 00 1", bus.progDataOut, bus.tcPulse);
    end
    cyc(0, 1, 3, 1, 0, 0, 3);
    n_checks++;
    if (bus.progDataOut !== 8'h08) begin n_fail++; $display("FAIL stat_kept: got %h expected 08", bus.progDataOut); end
  endtask

  task automatic test_rd_wr_together();
    cyc(1, 1, 0, 1, 8'h5A, 0, 1);
    n_checks++;
    if (bus.progDataOut !== 8'h08) begin n_fail++; $display("FAIL rdwr_hold: got %h expected 08", bus.progDataOut); end
    cyc(1, 0, 0, 1, 8'h66, 0, 1);
    n_checks++;
    if (bus.addrOut !== 16'h665A) begin n_fail++; $display("FAIL rdwr_ptr: got %h expected 665a", bus.addrOut); end
  endtask

  task automatic test_master_clear();
    cyc(1, 0, 3, 2, 0, 1, 2);
    n_checks++;
    if (bus.chMask !== 4'hF || bus.addrOut !== 16'h0 || bus.tcPulse !== 1'b0 || bus.progDataOut !== 8'h0) begin
      n_fail++; $display("FAIL mclr: got mask %h addr %h tc %b dout %h expected f 0000 0 00",
                         bus.chMask, bus.addrOut, bus.tcPulse, bus.progDataOut);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.addrOut !== 16'h0000) begin n_fail++; $display("FAIL mclr_regs: got %h expected 0000", bus.addrOut); end
  endtask

  task automatic test_random();
    int r, wr, rd, func, ch, din, st, sch;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      wr = 0; rd = 0; func = 0; ch = $urandom_range(0, 3);
      din = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
      if (r < 6) begin
        wr = 1; func = $urandom_range(0, 1);
        if (r == 0) rd = 1;
      end else if (r < 8) begin
        wr = 1; func = 2; din = $urandom_range(0, 7);
      end else if (r < 10) begin
        rd = 1; func = $urandom_range(0, 1);
      end else if (r < 12) begin
        rd = 1; func = 3; ch = 1;
      end else if (r == 12) begin
        wr = 1; func = 3; ch = ($urandom_range(0, 29) == 0) ? 2 : (($urandom_range(0, 1) == 0) ? 0 : 3);
      end
      st  = ($urandom_range(0, 9) < 7) ? 1 : 0;
      sch = $urandom_range(0, 3);
      cyc(wr, rd, func, ch, din, st, sch);
      n_checks++;
      if (bus.progDataOut !== e_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h expected %h", n, bus.progDataOut, e_dout); end
      n_checks++;
      if (bus.addrOut !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, bus.addrOut, e_addr); end
      n_checks++;
      if (bus.tcPulse !== e_tcp) begin n_fail++; $display("FAIL rnd_tc[%0d]: got %b expected %b", n, bus.tcPulse, e_tcp); end
      n_checks++;
      if (bus.chMask !== m_mask) begin n_fail++; $display("FAIL rnd_mask[%0d]: got %h expected %h", n, bus.chMask, m_mask); end
    end
  endtask

`ifdef DMA_ADDR_HOLD_EN
  task automatic test_addr_hold();
    cyc(1, 0, 3, 0, 0, 0, 3);
    cyc(1, 0, 2, 3, 8'h04, 0, 3);
    cyc(1, 0, 0, 3, 8'hF0, 0, 3);
    cyc(1, 0, 0, 3, 8'h00, 0, 3);
    cyc(1, 0, 1, 3, 8'h01, 0, 3);
    cyc(1, 0, 1, 3, 8'h00, 0, 3);
    cyc(0, 0, 0, 0, 0, 1, 3);
    n_checks++;
    if (bus.addrOut !== 16'h00F0 || bus.tcPulse !== 1'b0) begin
      n_fail++; $display("FAIL hold1: got addr %h tc %b expected 00f0 0", bus.addrOut, bus.tcPulse);
    end
    cyc(0, 0, 0, 0, 0, 1, 3);
    n_checks++;
    if (bus.addrOut !== 16'h00F0 || bus.tcPulse !== 1'b1) begin
      n_fail++; $display("FAIL hold2: got addr %h tc %b expected 00f0 1", bus.addrOut, bus.tcPulse);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_program_readback();
    test_steps();
    test_autoinit_decrement();
    test_ptr_clear();
    test_write_step_collision();
    test_status_collision();
    test_rd_wr_together();
    test_master_clear();
`ifdef DMA_ADDR_HOLD_EN
    test_addr_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
